// File: rtl/fixed_att_residual_add.sv
// Residual add: buffers skip beats in a FIFO and adds each attention beat
// to the oldest skip beat, with fixed-point alignment and saturation.
module fixed_att_residual_add #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_FRAC_WIDTH = 1,
  parameter int ATT_WIDTH       = 8,
  parameter int ATT_FRAC_WIDTH  = 1,
  parameter int OUT_WIDTH       = 8,
  parameter int OUT_FRAC_WIDTH  = 1,
  parameter int PARALLELISM     = 9,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] skip_in,
  input  logic skip_in_valid,
  output logic skip_in_ready,
  input  logic [PARALLELISM-1:0][ATT_WIDTH-1:0] att_in,
  input  logic att_in_valid,
  output logic att_in_ready,
  output logic [PARALLELISM-1:0][OUT_WIDTH-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic sat_flag
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int F =
    (DATA_FRAC_WIDTH > ATT_FRAC_WIDTH) ? DATA_FRAC_WIDTH : ATT_FRAC_WIDTH;
  localparam int DI = DATA_WIDTH - DATA_FRAC_WIDTH;
  localparam int AI = ATT_WIDTH - ATT_FRAC_WIDTH;
  localparam int IW = (DI > AI) ? DI : AI;
  localparam int SW = IW + F + 1;
  localparam int SH_UP = (OUT_FRAC_WIDTH > F) ? OUT_FRAC_WIDTH - F : 0;
  localparam int SH_DN = (F > OUT_FRAC_WIDTH) ? F - OUT_FRAC_WIDTH : 0;
  localparam int RW = SW + SH_UP;
  localparam int CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;
  localparam logic signed [CW-1:0] OMAX =
    {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN = ~OMAX;

  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] skip_beat_t;
  typedef logic [PARALLELISM-1:0][OUT_WIDTH-1:0] out_beat_t;

  skip_beat_t mem_q [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  out_beat_t data_q, data_d;
  logic valid_q, valid_d;
  logic sat_q, sat_d;

  logic push, fire, out_free, sat_any;
  out_beat_t sum;
  skip_beat_t rd_data;

  assign out_free = !valid_q || data_out_0_ready;
  assign skip_in_ready = count_q < CNTW'(FIFO_DEPTH);
  assign att_in_ready = (count_q != '0) && out_free;
  assign push = skip_in_valid && skip_in_ready;
  assign fire = att_in_valid && att_in_ready;
  assign rd_data = mem_q[rd_ptr_q];

  // Align both operands to F fractional bits, add, rescale, then clip.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] sk;
    logic signed [ATT_WIDTH-1:0] at;
    logic signed [CW-1:0] a, b, s;
    sum = '0;
    sat_any = 1'b0;
    for (int i = 0; i < PARALLELISM; i++) begin
      sk = rd_data[i];
      at = att_in[i];
      a = CW'(sk) <<< (F - DATA_FRAC_WIDTH);
      b = CW'(at) <<< (F - ATT_FRAC_WIDTH);
      s = a + b;
      s = s <<< SH_UP;
      s = s >>> SH_DN;
      if (s > OMAX) begin
        sum[i] = OMAX[OUT_WIDTH-1:0];
        sat_any = 1'b1;
      end else if (s < OMIN) begin
        sum[i] = OMIN[OUT_WIDTH-1:0];
        sat_any = 1'b1;
      end else begin
        sum[i] = s[OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTRW'(push);
    rd_ptr_d = rd_ptr_q + PTRW'(fire);
    count_d = count_q;
    unique case ({push, fire})
      2'b10: count_d = count_q + 1'b1;
      2'b01: count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = valid_q;
    data_d = data_q;
    if (fire) begin
      valid_d = 1'b1;
      data_d = sum;
    end else if (data_out_0_ready) begin
      valid_d = 1'b0;
    end
    sat_d = sat_q || (fire && sat_any);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= skip_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      sat_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q <= data_d;
      sat_q <= sat_d;
    end
  end

  assign data_out_0 = data_q;
  assign data_out_0_valid = valid_q;
  assign fifo_count = count_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_fixed_att_residual_add.sv
// Directed bench for fixed_att_residual_add: default instance plus one
// with ATT_FRAC_WIDTH=3 for fractional alignment.
module tb_fixed_att_residual_add;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [71:0] skip, att, dout;
  logic skv, atv, ordy, skr, atr, dv, sat;
  logic [3:0] cnt;

  logic [71:0] skip3, att3, dout3;
  logic skv3, atv3, ordy3, skr3, atr3, dv3, sat3;
  logic [3:0] cnt3;

  int checks = 0;
  int errors = 0;

  fixed_att_residual_add u_dut (
    .clk(clk), .rst(rst),
    .skip_in(skip), .skip_in_valid(skv), .skip_in_ready(skr),
    .att_in(att), .att_in_valid(atv), .att_in_ready(atr),
    .data_out_0(dout), .data_out_0_valid(dv),
    .data_out_0_ready(ordy),
    .fifo_count(cnt), .sat_flag(sat)
  );

  fixed_att_residual_add #(.ATT_FRAC_WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .skip_in(skip3), .skip_in_valid(skv3), .skip_in_ready(skr3),
    .att_in(att3), .att_in_valid(atv3), .att_in_ready(atr3),
    .data_out_0(dout3), .data_out_0_valid(dv3),
    .data_out_0_ready(ordy3),
    .fifo_count(cnt3), .sat_flag(sat3)
  );

  function automatic logic [71:0] rep(input logic [7:0] b);
    return {9{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    skv = 0; atv = 0; ordy = 1; skip = '0; att = '0;
    skv3 = 0; atv3 = 0; ordy3 = 1; skip3 = '0; att3 = '0;
    #1;
    chk("rst_valid", dv, 0);
    chk("rst_count", cnt, 0);
    chk("rst_data", dout, 0);
    chk("rst_sat", sat, 0);
    chk("rst_skip_rdy", skr, 1);
    chk("rst_att_rdy", atr, 0);
    #20 rst = 1'b0;
    tick;

    // basic add 3.0 + 2.0
    skv = 1; skip = rep(8'h06); tick; skv = 0;
    chk("basic_count1", cnt, 1);
    chk("basic_att_rdy", atr, 1);
    atv = 1; att = rep(8'h04); tick; atv = 0;
    chk("basic_valid", dv, 1);
    chk("basic_data", dout, rep(8'h0A));
    chk("basic_count0", cnt, 0);
    chk("basic_sat", sat, 0);
    tick;
    chk("basic_valid_clr", dv, 0);

    // saturation both ways, then sticky flag
    skv = 1; skip = rep(8'h64); tick;
    skip = rep(8'h9C); tick; skv = 0;
    atv = 1; att = rep(8'h64); tick;
    chk("sat_pos", dout, rep(8'h7F));
    chk("sat_flag", sat, 1);
    att = rep(8'h9C); tick; atv = 0;
    chk("sat_neg", dout, rep(8'h80));
    skv = 1; skip = rep(8'h06); tick; skv = 0;
    atv = 1; att = rep(8'h04); tick; atv = 0;
    chk("sat_after", dout, rep(8'h0A));
    chk("sat_sticky", sat, 1);
    tick;

    // fill FIFO to depth
    skv = 1;
    for (int k = 1; k <= 8; k++) begin
      skip = rep(8'(k)); tick;
      chk("fill_count", cnt, k);
    end
    chk("full_skip_rdy", skr, 0);
    skip = rep(8'h63); tick; skv = 0;
    chk("full_hold", cnt, 8);

    // streaming with wrap
    atv = 1; att = rep(8'h00); tick;
    chk("stream0", dout, rep(8'h01));
    chk("stream0_cnt", cnt, 7);
    for (int j = 1; j <= 20; j++) begin
      skv = 1; skip = rep(8'(8 + j)); att = rep(8'(j)); tick;
      chk("stream", dout, rep(8'(2 * j + 1)));
      chk("stream_cnt", cnt, 7);
    end
    skv = 0; att = rep(8'h00);
    for (int k = 0; k < 7; k++) begin
      tick;
      chk("drain", dout, rep(8'(22 + k)));
      chk("drain_cnt", cnt, 6 - k);
    end
    atv = 0; tick;
    chk("drain_empty", cnt, 0);
    chk("drain_valid", dv, 0);

    // backpressure
    skv = 1; skip = rep(8'h10); tick;
    skip = rep(8'h20); tick; skv = 0;
    ordy = 0; atv = 1; att = rep(8'h01); tick;
    chk("bp_valid", dv, 1);
    chk("bp_data", dout, rep(8'h11));
    chk("bp_att_rdy", atr, 0);
    att = rep(8'h02); tick;
    chk("bp_hold", dout, rep(8'h11));
    chk("bp_hold_cnt", cnt, 1);
    chk("bp_hold_valid", dv, 1);
    ordy = 1; #1;
    chk("bp_release_rdy", atr, 1);
    tick; atv = 0;
    chk("bp_next", dout, rep(8'h22));
    chk("bp_next_cnt", cnt, 0);
    tick;

    // empty FIFO with same-cycle push: no bypass
    skv = 1; skip = rep(8'h05); atv = 1; att = rep(8'h03); #1;
    chk("empty_att_rdy", atr, 0);
    tick; skv = 0;
    chk("empty_nofire_valid", dv, 0);
    chk("empty_nofire_cnt", cnt, 1);
    tick; atv = 0;
    chk("empty_fire", dout, rep(8'h08));
    chk("empty_fire_valid", dv, 1);
    tick;

    // fractional alignment, att has 3 frac bits
    skv3 = 1; skip3 = rep(8'h03); tick;
    tick;
    skip3 = rep(8'hFD); tick; skv3 = 0;
    atv3 = 1; att3 = rep(8'h0C); tick;
    chk("frac_exact", dout3, rep(8'h06));
    att3 = rep(8'h0D); tick;
    chk("frac_floor", dout3, rep(8'h06));
    att3 = rep(8'hF3); tick; atv3 = 0;
    chk("frac_floor_neg", dout3, rep(8'hF9));
    chk("frac_cnt", cnt3, 0);

    // async reset mid-stream
    skv = 1;
    for (int k = 0; k < 4; k++) begin
      skip = rep(8'h70); tick;
    end
    skv = 0; atv = 1; att = rep(8'h70); tick; atv = 0;
    ordy = 0;
    chk("pre_rst_cnt", cnt, 3);
    chk("pre_rst_valid", dv, 1);
    chk("pre_rst_data", dout, rep(8'h7F));
    chk("pre_rst_sat", sat, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", dv, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_skip_rdy", skr, 1);
    chk("mid_rst_att_rdy", atr, 0);
    #2 rst = 1'b0;
    ordy = 1;
    tick;
    skv = 1; skip = rep(8'h06); tick; skv = 0;
    atv = 1; att = rep(8'h04); tick; atv = 0;
    chk("resume_data", dout, rep(8'h0A));
    chk("resume_cnt", cnt, 0);
    chk("resume_sat", sat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
